jmp_ctrl: RTL and testbench

Jump redirect controller for the dual-issue pipeline. It takes the resolved jump decision from the branch unit in the execute stage and kills the younger i1 slot when i0 jumps. It flushes the front-end stages and holds a PC redirect to fetch until fetch accepts it. It also stalls the execute stage while a redirect is pending, and raises a misaligned-target exception instead of redirecting when the target is not 4-byte aligned.

---
 rtl/riscv_defs.sv | 14 +
 rtl/jmp_ctrl_sat_cnt.sv | 19 +
 rtl/jmp_ctrl.sv | 116 +++++++++++
 tb/tb_jmp_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defs.sv
// Shared RISC-V pipeline definitions: statistics counter width and exception cause codes.
package riscv_defs;

    localparam int unsigned STAT_CNT_W = 32;

    // Instruction-address-misaligned cause, raised by the trap unit alongside jmp_misalign.
    localparam logic [3:0] EXC_INSN_MISALIGN = 4'd0;

    // Bit 0 is cleared by the datapath for JALR, so only bit 1 decides alignment.
    function automatic logic jmp_target_misaligned(input logic [31:0] addr);
        return addr[1];
    endfunction

endpackage

// File: rtl/jmp_ctrl_sat_cnt.sv
// sat_cnt: W-bit counter that increments on inc and sticks at all-ones.
module sat_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/jmp_ctrl.sv
// Jump redirect controller: kills i1, flushes the front end and holds a PC redirect until fetch accepts.
// Statistics counters are built only when JMP_CTRL_STATS_EN is defined.
module jmp_ctrl
    import riscv_defs::*;
#(
    parameter int unsigned CNT_W = STAT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exe_valid,
    input  logic             take_jmp,
    input  logic             jmp_src_i0,
    input  logic [31:0]      jmp_addr,
    input  logic             fetch_ready,
    output logic             kill_i1,
    output logic             flush,
    output logic             stall_exe,
    output logic             fetch_redirect,
    output logic [31:0]      fetch_pc,
    output logic             jmp_misalign,
    output logic [CNT_W-1:0] stat_jmp_cnt,
    output logic [CNT_W-1:0] stat_stall_cnt
);

    typedef enum logic {
        IDLE,
        REDIRECT
    } jmp_state_t;

    jmp_state_t  state;
    jmp_state_t  state_nxt;
    logic [31:0] redirect_pc;
    logic        acc;
    logic        misal;

    // Combinational outputs are forced low while rst is high, even if state has not cleared yet.
    assign acc   = !rst && exe_valid && take_jmp && (state == IDLE);
    assign misal = jmp_target_misaligned(jmp_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_pc <= '0;
        end else if (acc && !misal) begin
            redirect_pc <= jmp_addr & ~32'd1;
        end
    end

    always_comb begin
        state_nxt      = state;
        kill_i1        = 1'b0;
        flush          = 1'b0;
        stall_exe      = 1'b0;
        fetch_redirect = 1'b0;
        fetch_pc       = '0;
        jmp_misalign   = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        kill_i1 = jmp_src_i0;
                        if (misal) begin
                            jmp_misalign = 1'b1;
                        end else begin
                            flush     = 1'b1;
                            state_nxt = REDIRECT;
                        end
                    end
                end
                REDIRECT: begin
                    fetch_redirect = 1'b1;
                    fetch_pc       = redirect_pc;
                    flush          = 1'b1;
                    stall_exe      = 1'b1;
                    if (fetch_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef JMP_CTRL_STATS_EN
    logic inc_jmp;
    logic inc_stall;

    assign inc_jmp   = acc && !misal;
    assign inc_stall = !rst && (state == REDIRECT) && !fetch_ready;

    sat_cnt #(.W(CNT_W)) u_jmp_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc_jmp),
        .cnt (stat_jmp_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc_stall),
        .cnt (stat_stall_cnt)
    );
`else
    assign stat_jmp_cnt   = '0;
    assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_jmp_ctrl.sv
// Self-checking bench for jmp_ctrl: behavioural model compared every cycle plus directed literal checks.
module tb_jmp_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exe_valid = 1'b0;
    logic        take_jmp = 1'b0;
    logic        jmp_src_i0 = 1'b0;
    logic [31:0] jmp_addr = '0;
    logic        fetch_ready = 1'b0;

    logic        kill_i1, flush, stall_exe, fetch_redirect, jmp_misalign;
    logic [31:0] fetch_pc;
    logic [31:0] stat_jmp_cnt, stat_stall_cnt;

    logic        kill_i1_b, flush_b, stall_exe_b, fetch_redirect_b, jmp_misalign_b;
    logic [31:0] fetch_pc_b;
    logic [3:0]  stat_jmp_cnt_b, stat_stall_cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jmp_ctrl dut (
        .clk(clk), .rst(rst), .exe_valid(exe_valid), .take_jmp(take_jmp),
        .jmp_src_i0(jmp_src_i0), .jmp_addr(jmp_addr), .fetch_ready(fetch_ready),
        .kill_i1(kill_i1), .flush(flush), .stall_exe(stall_exe),
        .fetch_redirect(fetch_redirect), .fetch_pc(fetch_pc), .jmp_misalign(jmp_misalign),
        .stat_jmp_cnt(stat_jmp_cnt), .stat_stall_cnt(stat_stall_cnt)
    );

    jmp_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .exe_valid(exe_valid), .take_jmp(take_jmp),
        .jmp_src_i0(jmp_src_i0), .jmp_addr(jmp_addr), .fetch_ready(fetch_ready),
        .kill_i1(kill_i1_b), .flush(flush_b), .stall_exe(stall_exe_b),
        .fetch_redirect(fetch_redirect_b), .fetch_pc(fetch_pc_b), .jmp_misalign(jmp_misalign_b),
        .stat_jmp_cnt(stat_jmp_cnt_b), .stat_stall_cnt(stat_stall_cnt_b)
    );

    // Model: a redirect is either outstanding (with its target) or not; counts are unbounded integers.
    bit          m_pending = 1'b0;
    logic [31:0] m_pc = '0;
    longint      m_jmps = 0;
    longint      m_stalls = 0;

    function automatic longint sat(input longint v, input int bits);
        longint lim;
        lim = (longint'(1) << bits) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_pending = 1'b0;
            m_pc      = '0;
            m_jmps    = 0;
            m_stalls  = 0;
        end else if (m_pending) begin
            if (fetch_ready) m_pending = 1'b0;
            else             m_stalls++;
        end else if (exe_valid && take_jmp && !jmp_addr[1]) begin
            m_pending = 1'b1;
            m_pc      = {jmp_addr[31:1], 1'b0};
            m_jmps++;
        end
    end

    always @(negedge clk) begin
        logic        e_kill, e_flush, e_stall, e_redir, e_mis;
        logic [31:0] e_pc;
        longint      e_j32, e_s32, e_j4, e_s4;
        e_kill = 0; e_flush = 0; e_stall = 0; e_redir = 0; e_mis = 0; e_pc = '0;
        if (!rst) begin
            if (m_pending) begin
                e_redir = 1; e_pc = m_pc; e_flush = 1; e_stall = 1;
            end else if (exe_valid && take_jmp) begin
                e_kill = jmp_src_i0;
                if (jmp_addr[1]) e_mis = 1;
                else             e_flush = 1;
            end
        end
`ifdef JMP_CTRL_STATS_EN
        e_j32 = sat(m_jmps, 32); e_s32 = sat(m_stalls, 32);
        e_j4  = sat(m_jmps, 4);  e_s4  = sat(m_stalls, 4);
`else
        e_j32 = 0; e_s32 = 0; e_j4 = 0; e_s4 = 0;
`endif
        chk("kill_i1", kill_i1, e_kill);
        chk("flush", flush, e_flush);
        chk("stall_exe", stall_exe, e_stall);
        chk("fetch_redirect", fetch_redirect, e_redir);
        chk("fetch_pc", fetch_pc, e_pc);
        chk("jmp_misalign", jmp_misalign, e_mis);
        chk("stat_jmp_cnt", stat_jmp_cnt, e_j32);
        chk("stat_stall_cnt", stat_stall_cnt, e_s32);
        chk("w4_fetch_pc", fetch_pc_b, e_pc);
        chk("w4_stat_jmp_cnt", stat_jmp_cnt_b, e_j4);
        chk("w4_stat_stall_cnt", stat_stall_cnt_b, e_s4);
    end

    task automatic drive(input logic ev, input logic tj, input logic i0,
                         input logic [31:0] a, input logic fr);
        exe_valid = ev; take_jmp = tj; jmp_src_i0 = i0; jmp_addr = a; fetch_ready = fr;
        @(negedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 0);
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        longint en;
`ifdef JMP_CTRL_STATS_EN
        en = 1;
`else
        en = 0;
`endif
        do_reset();
        drive(0, 0, 0, 32'h0, 0);
        chk("reset_redirect", fetch_redirect, 0);
        chk("reset_jmp_cnt", stat_jmp_cnt, 0);
        next_cycle();

        // i0 jump to 0x100, fetch ready immediately
        drive(1, 1, 1, 32'h100, 1);
        chk("t1_kill", kill_i1, 1);
        chk("t1_flush", flush, 1);
        next_cycle();
        drive(0, 0, 0, 32'h0, 1);
        chk("t1_redirect", fetch_redirect, 1);
        chk("t1_pc", fetch_pc, 32'h100);
        chk("t1_stall", stall_exe, 1);
        next_cycle();
        drive(0, 0, 0, 32'h0, 1);
        chk("t1_idle_redirect", fetch_redirect, 0);
        chk("t1_idle_flush", flush, 0);
        next_cycle();

        // i1 jump to 0x2000, fetch busy for 3 cycles
        do_reset();
        drive(1, 1, 0, 32'h2000, 0);
        chk("t2_kill", kill_i1, 0);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 32'h0, (i == 3));
            chk("t2_pc_hold", fetch_pc, 32'h2000);
            next_cycle();
        end
        drive(0, 0, 0, 32'h0, 0);
        chk("t2_stall_cnt", stat_stall_cnt, 3 * en);
        chk("t2_jmp_cnt", stat_jmp_cnt, 1 * en);
        next_cycle();

        // misaligned i0 target
        drive(1, 1, 1, 32'h102, 1);
        chk("t3_misalign", jmp_misalign, 1);
        chk("t3_kill", kill_i1, 1);
        chk("t3_flush", flush, 0);
        next_cycle();
        drive(0, 0, 0, 32'h0, 1);
        chk("t3_no_redirect", fetch_redirect, 0);
        chk("t3_misalign_gone", jmp_misalign, 0);
        next_cycle();

        // JALR target with bit 0 set
        drive(1, 1, 0, 32'h101, 0);
        chk("t4_misalign", jmp_misalign, 0);
        next_cycle();
        drive(0, 0, 0, 32'h0, 1);
        chk("t4_pc", fetch_pc, 32'h100);
        next_cycle();

        // second jump during REDIRECT is ignored
        do_reset();
        drive(1, 1, 1, 32'h500, 0);
        next_cycle();
        drive(1, 1, 1, 32'h300, 0);
        chk("t5_pc", fetch_pc, 32'h500);
        chk("t5_kill", kill_i1, 0);
        next_cycle();
        drive(0, 0, 0, 32'h0, 1);
        chk("t5_pc_hold", fetch_pc, 32'h500);
        next_cycle();
        drive(0, 0, 0, 32'h0, 0);
        chk("t5_jmp_cnt", stat_jmp_cnt, 1 * en);
        next_cycle();

        // reset in the 2nd REDIRECT cycle
        drive(1, 1, 1, 32'h600, 0);
        next_cycle();
        drive(0, 0, 0, 32'h0, 0);
        next_cycle();
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 0);
        chk("t6_rst_redirect", fetch_redirect, 0);
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 32'h0, 0);
        chk("t6_after_redirect", fetch_redirect, 0);
        chk("t6_after_jmp_cnt", stat_jmp_cnt, 0);
        chk("t6_after_stall_cnt", stat_stall_cnt, 0);
        next_cycle();

        // 20 back-to-back jumps, 4-bit counter saturates
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, i[0], 32'h1000 + 32'(i * 4), 1);
            next_cycle();
            drive(0, 0, 0, 32'h0, 1);
            next_cycle();
        end
        drive(0, 0, 0, 32'h0, 0);
        chk("t7_w4_sat", stat_jmp_cnt_b, 15 * en);
        chk("t7_w32", stat_jmp_cnt, 20 * en);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
